reg_op_sequencer: RTL and testbench



---
 rtl/reg_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_reg_op_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_op_sequencer
// Brief    : Expands one opcode per handshake into a timed train of one-hot
//            control pulses for a cl/ld/inc/dec/sr/sl register.
// Revision : 1.0 - initial release
// ============================================================================
module reg_op_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [CNT_WIDTH-1:0]  cmd_cnt,
    input  logic                  cmd_fill,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] reg_q,
    output logic                  reg_cl,
    output logic                  reg_ld,
    output logic                  reg_inc,
    output logic                  reg_dec,
    output logic                  reg_sr,
    output logic                  reg_sl,
    output logic [DATA_WIDTH-1:0] reg_in,
    output logic                  reg_ir,
    output logic                  reg_il,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] c_OP_NOP  = 3'd0;
    localparam logic [2:0] c_OP_CLR  = 3'd1;
    localparam logic [2:0] c_OP_LOAD = 3'd2;
    localparam logic [2:0] c_OP_INC  = 3'd3;
    localparam logic [2:0] c_OP_DEC  = 3'd4;
    localparam logic [2:0] c_OP_SHR  = 3'd5;
    localparam logic [2:0] c_OP_SHL  = 3'd6;
    localparam logic [2:0] c_OP_ROR  = 3'd7;

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_WIDTH-1:0]    r_rem;
    logic [CNT_WIDTH-1:0]    w_rem_nxt;
    logic [5:0]              r_ctrl;
    logic [5:0]              w_ctrl_nxt;
    logic [2:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_fill;
    logic                    w_accept;
    logic                    w_is_repeat;
    logic                    w_unused_q;

    // Control vector order: {cl, ld, inc, dec, sr, sl}; ROR shares sr with SHR.
    function automatic logic [5:0] op_ctrl(input logic [2:0] op);
        logic [5:0] v;
        v = 6'b000000;
        case (op)
            c_OP_CLR:  v = 6'b100000;
            c_OP_LOAD: v = 6'b010000;
            c_OP_INC:  v = 6'b001000;
            c_OP_DEC:  v = 6'b000100;
            c_OP_SHR:  v = 6'b000010;
            c_OP_ROR:  v = 6'b000010;
            c_OP_SHL:  v = 6'b000001;
            default:   v = 6'b000000;
        endcase
        return v;
    endfunction

    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    assign w_is_repeat = (cmd_op >= c_OP_INC);

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_ctrl_nxt  = 6'b000000;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((cmd_op == c_OP_NOP) || (w_is_repeat && (cmd_cnt == c_CNT_ZERO))) begin
                        w_state_nxt = S_DONE;
                        w_rem_nxt   = c_CNT_ZERO;
                    end else begin
                        w_state_nxt = S_EXEC;
                        w_rem_nxt   = w_is_repeat ? cmd_cnt : c_CNT_ONE;
                        w_ctrl_nxt  = op_ctrl(cmd_op);
                    end
                end
            end
            S_EXEC: begin
                // remaining is always >= 1 here, so the decrement never wraps
                w_rem_nxt = r_rem - c_CNT_ONE;
                if (abort || (r_rem == c_CNT_ONE)) begin
                    w_state_nxt = S_DONE;
                    w_rem_nxt   = c_CNT_ZERO;
                end else begin
                    w_ctrl_nxt  = op_ctrl(r_op);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = c_CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= c_CNT_ZERO;
            r_ctrl  <= 6'b000000;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= c_OP_NOP;
            r_data <= '0;
            r_fill <= 1'b0;
        end else if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_fill <= cmd_fill;
        end
    end

    assign {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl} = r_ctrl;
    assign reg_in = r_data;

    // ROR feeds the live LSB back so each rotate step sees the updated value.
    assign reg_ir = (r_op == c_OP_SHR) ? r_fill :
                    (r_op == c_OP_ROR) ? reg_q[0] : 1'b0;
    assign reg_il = (r_op == c_OP_SHL) && r_fill;

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    assign w_unused_q = ^reg_q[DATA_WIDTH-1:1];

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_op_sequencer
// Brief    : Directed bench for reg_op_sequencer driving a behavioural register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [15:0] cmd_data = 16'h0;
    logic [3:0]  cmd_cnt = 4'd0;
    logic        cmd_fill = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] reg_q = 16'h0;
    logic        reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl;
    logic [15:0] reg_in;
    logic        reg_ir, reg_il, busy, done;
    logic [5:0]  w_ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    int          r_sel, r_total, r_multi, r_done_cyc, r_done_cnt, r_busy;
    logic [15:0] r_in1;
    logic        r_ir1, r_il1, r_tmo;

    reg_op_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
        .abort(abort), .reg_q(reg_q),
        .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
        .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_in(reg_in),
        .reg_ir(reg_ir), .reg_il(reg_il), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign w_ctrl = {reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl};

    // Behavioural general-purpose register driven by the sequencer; not reset.
    always @(posedge clk) begin
        if (reg_cl)       reg_q <= 16'h0;
        else if (reg_ld)  reg_q <= reg_in;
        else if (reg_inc) reg_q <= reg_q + 16'd1;
        else if (reg_dec) reg_q <= reg_q - 16'd1;
        else if (reg_sr)  reg_q <= {reg_ir, reg_q[15:1]};
        else if (reg_sl)  reg_q <= {reg_q[14:0], reg_il};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one command and observe every cycle until cmd_ready returns.
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] data,
                           input logic [3:0] cnt, input logic fill, input logic hold,
                           input int abort_at, input logic [5:0] mask);
        r_sel = 0; r_total = 0; r_multi = 0; r_done_cyc = 0; r_done_cnt = 0;
        r_busy = 0; r_in1 = 16'h0; r_ir1 = 1'b0; r_il1 = 1'b0; r_tmo = 1'b0;
        @(negedge clk);
        cmd_op = op; cmd_data = data; cmd_cnt = cnt; cmd_fill = fill; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            abort = 1'b0;
            if (cmd_ready) begin
                cmd_valid = 1'b0;
                break;
            end
            r_busy++;
            if (k == 1) begin
                r_in1 = reg_in; r_ir1 = reg_ir; r_il1 = reg_il;
            end
            if (done) begin
                r_done_cnt++;
                r_done_cyc = k;
            end
            if ((mask != 6'b0) && (w_ctrl == mask)) r_sel++;
            r_total += $countones(w_ctrl);
            if ($countones(w_ctrl) > 1) r_multi++;
            if (k == abort_at) abort = 1'b1;
            if (k == 40) r_tmo = 1'b1;
        end
        cmd_valid = 1'b0;
        check("timeout", {31'b0, r_tmo}, 32'd0);
        check("onehot", r_multi, 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy_done", {30'b0, busy, done}, 32'd0);
        check("rst_ctrl", {26'b0, w_ctrl}, 32'd0);
        check("rst_regin", {16'b0, reg_in}, 32'd0);
        check("rst_ir_il", {30'b0, reg_ir, reg_il}, 32'd0);
        rst_n = 1'b1;

        // LOAD
        run_cmd(3'd2, 16'hA5C3, 4'd0, 1'b0, 1'b0, 0, 6'b010000);
        check("load_pulses", r_sel, 32'd1);
        check("load_total", r_total, 32'd1);
        check("load_regin", {16'b0, r_in1}, 32'h0000A5C3);
        check("load_done_cyc", r_done_cyc, 32'd2);
        check("load_busy_cyc", r_busy, 32'd2);
        check("load_q", {16'b0, reg_q}, 32'h0000A5C3);

        // INC by 5 with cmd_valid held high throughout
        run_cmd(3'd2, 16'h0001, 4'd0, 1'b0, 1'b0, 0, 6'b010000);
        run_cmd(3'd3, 16'h0000, 4'd5, 1'b0, 1'b1, 0, 6'b001000);
        check("inc_pulses", r_sel, 32'd5);
        check("inc_total", r_total, 32'd5);
        check("inc_done_cnt", r_done_cnt, 32'd1);
        check("inc_done_cyc", r_done_cyc, 32'd6);
        check("inc_busy_cyc", r_busy, 32'd6);
        @(negedge clk);
        check("inc_no_reaccept", {31'b0, busy}, 32'd0);
        check("inc_q", {16'b0, reg_q}, 32'h00000006);

        // ROR
        run_cmd(3'd2, 16'h8001, 4'd0, 1'b0, 1'b0, 0, 6'b010000);
        run_cmd(3'd7, 16'h0000, 4'd1, 1'b0, 1'b0, 0, 6'b000010);
        check("ror1_pulses", r_sel, 32'd1);
        check("ror1_ir", {31'b0, r_ir1}, 32'd1);
        check("ror1_q", {16'b0, reg_q}, 32'h0000C000);
        run_cmd(3'd2, 16'h000F, 4'd0, 1'b0, 1'b0, 0, 6'b010000);
        run_cmd(3'd7, 16'h0000, 4'd4, 1'b0, 1'b0, 0, 6'b000010);
        check("ror4_pulses", r_sel, 32'd4);
        check("ror4_q", {16'b0, reg_q}, 32'h0000F000);

        // SHL with fill 1, then zero-count SHR
        run_cmd(3'd2, 16'h0000, 4'd0, 1'b0, 1'b0, 0, 6'b010000);
        run_cmd(3'd6, 16'h0000, 4'd3, 1'b1, 1'b0, 0, 6'b000001);
        check("shl_pulses", r_sel, 32'd3);
        check("shl_il", {31'b0, r_il1}, 32'd1);
        check("shl_q", {16'b0, reg_q}, 32'h00000007);
        run_cmd(3'd5, 16'h0000, 4'd0, 1'b1, 1'b0, 0, 6'b000010);
        check("shr0_total", r_total, 32'd0);
        check("shr0_done_cyc", r_done_cyc, 32'd1);
        check("shr0_busy_cyc", r_busy, 32'd1);
        check("shr0_q", {16'b0, reg_q}, 32'h00000007);

        // SHR with fill 1 on 0x0004 by 2 -> 0xC001
        run_cmd(3'd2, 16'h0004, 4'd0, 1'b0, 1'b0, 0, 6'b010000);
        run_cmd(3'd5, 16'h0000, 4'd2, 1'b1, 1'b0, 0, 6'b000010);
        check("shr2_ir", {31'b0, r_ir1}, 32'd1);
        check("shr2_q", {16'b0, reg_q}, 32'h0000C001);

        // CLR and NOP
        run_cmd(3'd1, 16'h0000, 4'd9, 1'b0, 1'b0, 0, 6'b100000);
        check("clr_pulses", r_sel, 32'd1);
        check("clr_q", {16'b0, reg_q}, 32'h00000000);
        run_cmd(3'd0, 16'h1234, 4'd7, 1'b0, 1'b0, 0, 6'b000000);
        check("nop_total", r_total, 32'd0);
        check("nop_done_cyc", r_done_cyc, 32'd1);

        // DEC by 10 aborted in the 3rd EXEC cycle
        run_cmd(3'd2, 16'h0064, 4'd0, 1'b0, 1'b0, 0, 6'b010000);
        run_cmd(3'd4, 16'h0000, 4'd10, 1'b0, 1'b0, 3, 6'b000100);
        check("abort_pulses", r_sel, 32'd3);
        check("abort_done_cyc", r_done_cyc, 32'd4);
        check("abort_done_cnt", r_done_cnt, 32'd1);
        check("abort_q", {16'b0, reg_q}, 32'h00000061);

        // Reset during SHR by 8: two shifts land before reset
        run_cmd(3'd2, 16'hFF00, 4'd0, 1'b0, 1'b0, 0, 6'b010000);
        @(negedge clk);
        cmd_op = 3'd5; cmd_cnt = 4'd8; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_ctrl", {26'b0, w_ctrl}, 32'd0);
        check("rstmid_flags", {29'b0, busy, done, cmd_ready}, 32'd1);
        check("rstmid_regin", {16'b0, reg_in}, 32'd0);
        check("rstmid_q", {16'b0, reg_q}, 32'h00003FC0);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r_done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) r_done_cnt++;
        end
        check("rstmid_no_done", r_done_cnt, 32'd0);
        check("rstmid_ready", {31'b0, cmd_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
